sdf_r2_stage: RTL and testbench
===============================

# sdf_r2_stage

Parametrised radix-2 single-path delay-feedback (SDF) FFT stage with built-in twiddle rotation. It is the generalised successor of the fixed-width stage: data width, FFT size, stage index and forward/inverse mode are all parameters. It tolerates input bubbles, realigns on a start-of-frame strobe, and uses rounded and saturated fixed-point arithmetic. Instances are chained, STAGE = 1..LOG2_N, to form a streaming N-point FFT/IFFT.

## Interface
- DATA_W, 16, signed two's-complement width of each I/Q component
- TW_W, 16, twiddle width, Q1.(TW_W-1)
- LOG2_N, 4, log2 of the FFT size N
- STAGE, 1, stage index, 1..LOG2_N; delay depth D = 2^(LOG2_N-STAGE)
- INVERSE, 0, 1 = conjugate twiddles (IFFT)

- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- di_en  in  1  input sample valid
- di_sof  in  1  first sample of a frame; qualified by di_en
- di_re / di_im  in  DATA_W  input sample
- do_en  out  1  output sample valid
- do_re / do_im  out  DATA_W  output sample

## Operation
- cnt, width LOG2_N-STAGE+1, counts accepted samples modulo 2D; it advances only when di_en=1 and holds during bubbles.
- di_sof with di_en: this sample is treated as cnt=0; primed is cleared; the counter becomes 1 next cycle.
- The delay line has D complex entries and shifts only on accepted samples. Its contents are not reset.
- First half (cnt MSB=0): the input is written to the delay line. The stage emits the delay-line head (the difference stored in the previous block), rotated by the twiddle.
- Second half (cnt MSB=1), with a = delay head and b = input: the stage emits a+b unrotated (twiddle forced to 1), and a−b is written to the delay line.
- Twiddle address = k << (STAGE−1), with k = cnt[LOG2_N-STAGE-1:0]. If STAGE = LOG2_N, k is empty and the address is 0.
- Twiddle value:
  - forward: W = cos(2πa/N) − j·sin(2πa/N)
  - INVERSE: the conjugate of W
- Complex multiply:
  - full-precision products, sum width DATA_W+TW_W+1
  - round half-up at bit TW_W−2, arithmetic shift right by TW_W−1
  - saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]
- Butterfly sum/difference is computed at DATA_W+1 bits, then saturated to DATA_W (scaling per Configuration).
- primed is set on the first second-half sample after reset or di_sof. Output is produced only for samples accepted while primed is set or being set.

## Timing
- Reset values: do_en=0, do_re=0, do_im=0, cnt=0, primed=0, pipeline valid bits=0.
- Latency is exactly 2 cycles from an accepted input to its output:
  - register 1 after the butterfly/mux plus twiddle lookup
  - register 2 after the multiplier and saturation
- do_en equals (di_en & primed-condition) delayed 2 cycles. Bubbles pass through unchanged and occupy the same slots.
- The first output appears 2 cycles after the (D+1)-th accepted sample of a frame.
- Flush: the differences of the last block leave only when D further samples (typically zeros) are accepted.
- cnt wraps from 2D−1 to 0 without a gap; back-to-back frames stream continuously.
- Reset asserted mid-frame: all state clears immediately; after release the stage waits for a new frame.
- di_sof while di_en=0 is ignored.

## Configuration
- SDF_STAGE_SCALE_EN defined:
  - butterfly sum and difference are divided by 2 with round half-up: (x+1)>>>1 at DATA_W+1 bits, then saturate
  - the first-half pass-through is also scaled by 1/2, so the stage gain is 1/2
- SDF_STAGE_SCALE_EN undefined: no scaling; sum and difference saturate directly to DATA_W.

## Structure
- Package sdf_pkg holds:
  - default widths
  - functions sat_to_w(value, width) and round_shift(value, shift)
  - the twiddle quantisation rule: round(2^(TW_W−1)·cos), clamped to 2^(TW_W−1)−1
- Sub-module sdf_twiddle_rom (LOG2_N, TW_W, INVERSE): combinational addr → tw_re/tw_im, with N/2 entries.
- Delay line, counter, butterfly, multiplier and pipeline registers stay in sdf_r2_stage.

## Test plan
- Defaults apply unless stated: N=16, STAGE=1, D=8, forward, no scaling.
- Impulse: x0=1000, then 23 zeros → first output 1000+0j at cycle 8+2; 8 cycles later diff k=0 gives 1000+0j; all other outputs 0.
- Twiddle: a=1000 at k=2, all other samples 0 → second-block k=2 output = 707−707j (1000·23170/32768 rounded). With INVERSE=1: 707+707j.
- Saturation: a=b=32767 → sum output 32767. With SDF_STAGE_SCALE_EN: sum 32767, diff 0, impulse of 1000 gives 500.
- Bubbles: di_en toggled 1,0,0,1 through a frame → outputs identical to the gapless run; each do_en pulse lags its di_en by 2 cycles.
- di_sof mid-block at cnt=5 → counter restarts; no output until 8 new samples are accepted; outputs match a fresh frame.
- Reset mid-frame → do_en, do_re and do_im are 0 while rstn=0; behaviour after release matches a cold start.

Source files
------------

// File: rtl/sdf_pkg.sv
// Shared widths and fixed-point helpers for the radix-2 SDF FFT stage family.
package sdf_pkg;

  localparam int unsigned SDF_DATA_W = 16;
  localparam int unsigned SDF_TW_W   = 16;
  localparam int unsigned SDF_LOG2_N = 4;

  // Clamp a signed value into a two's-complement field of the given width.
  function automatic longint sat_to_w(input longint value, input int unsigned width);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Arithmetic shift right with round half-up.
  function automatic longint round_shift(input longint value, input int unsigned shift);
    if (shift == 0) return value;
    return (value + (64'sd1 <<< (shift - 1))) >>> shift;
  endfunction

  // Twiddle quantisation: round(2^(tw_w-1) * v), top code clamped since +1.0 is not representable.
  function automatic int tw_quant(input real v, input int unsigned tw_w);
    real scaled;
    int  q;
    int  top;
    scaled = v * (2.0 ** (tw_w - 1));
    q      = $rtoi($floor(scaled + 0.5));
    top    = (32'sd1 <<< (tw_w - 1)) - 32'sd1;
    if (q > top) q = top;
    return q;
  endfunction

endpackage

// File: rtl/sdf_twiddle_rom.sv
// Combinational twiddle table, N/2 entries of W^a = cos - j*sin (conjugated for the inverse transform).
module sdf_twiddle_rom
  import sdf_pkg::*;
#(
  parameter int unsigned LOG2_N  = SDF_LOG2_N,
  parameter int unsigned TW_W    = SDF_TW_W,
  parameter bit          INVERSE = 1'b0
) (
  input  logic        [LOG2_N-2:0] addr,
  output logic signed [TW_W-1:0]   tw_re,
  output logic signed [TW_W-1:0]   tw_im
);

  localparam int unsigned NH     = 2 ** (LOG2_N - 1);
  localparam real         TWO_PI = 6.283185307179586;

  logic signed [TW_W-1:0] cos_tab [NH];
  logic signed [TW_W-1:0] sin_tab [NH];

  for (genvar i = 0; i < NH; i++) begin : g_tab
    localparam real ANG = TWO_PI * real'(i) / real'(2 * NH);
    assign cos_tab[i] = TW_W'(tw_quant($cos(ANG), TW_W));
    assign sin_tab[i] = TW_W'(tw_quant($sin(ANG), TW_W));
  end

  always_comb begin
    tw_re = cos_tab[addr];
    tw_im = INVERSE ? sin_tab[addr] : -sin_tab[addr];
  end

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage with twiddle rotation, 2-cycle latency.
// Define SDF_STAGE_SCALE_EN to halve butterfly outputs and pass-through (stage gain 1/2).
module sdf_r2_stage
  import sdf_pkg::*;
#(
  parameter int unsigned DATA_W  = SDF_DATA_W,
  parameter int unsigned TW_W    = SDF_TW_W,
  parameter int unsigned LOG2_N  = SDF_LOG2_N,
  parameter int unsigned STAGE   = 1,
  parameter bit          INVERSE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     di_en,
  input  logic                     di_sof,
  input  logic signed [DATA_W-1:0] di_re,
  input  logic signed [DATA_W-1:0] di_im,
  output logic                     do_en,
  output logic signed [DATA_W-1:0] do_re,
  output logic signed [DATA_W-1:0] do_im
);

  localparam int unsigned D  = 2 ** (LOG2_N - STAGE);
  localparam int unsigned CW = LOG2_N - STAGE + 1;
  localparam int unsigned AW = LOG2_N - 1;
  localparam int unsigned SW = DATA_W + 1;
  localparam int unsigned MW = DATA_W + TW_W;
  localparam int unsigned PW = DATA_W + TW_W + 1;

  function automatic logic signed [DATA_W-1:0] bf_fit(input logic signed [SW-1:0] v);
`ifdef SDF_STAGE_SCALE_EN
    return DATA_W'(sat_to_w(round_shift(64'(v), 1), DATA_W));
`else
    return DATA_W'(sat_to_w(64'(v), DATA_W));
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] pass_fit(input logic signed [DATA_W-1:0] v);
`ifdef SDF_STAGE_SCALE_EN
    return DATA_W'(round_shift(64'(v), 1));
`else
    return v;
`endif
  endfunction

  logic [CW-1:0]            cnt;
  logic [CW-1:0]            eff_cnt;
  logic                     primed;
  logic                     second_c;
  logic                     valid_c;
  logic signed [DATA_W-1:0] dl_re [D];
  logic signed [DATA_W-1:0] dl_im [D];
  logic signed [DATA_W-1:0] head_re, head_im;
  logic signed [SW-1:0]     sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_W-1:0] x_re, x_im, wr_re, wr_im;
  logic [AW-1:0]            tw_addr;
  logic signed [TW_W-1:0]   tw_re, tw_im;

  // A qualified start-of-frame forces this sample to slot 0.
  always_comb begin
    eff_cnt  = (di_en && di_sof) ? '0 : cnt;
    second_c = eff_cnt[CW-1];
    valid_c  = di_en && (second_c || (primed && !di_sof));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (di_en) begin
      cnt    <= eff_cnt + CW'(1);
      primed <= second_c || (primed && !di_sof);
    end
  end

  // Feedback delay line; contents are don't-care until written within a frame.
  always_ff @(posedge clk) begin
    if (di_en) begin
      for (int i = int'(D) - 1; i > 0; i--) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
      dl_re[0] <= wr_re;
      dl_im[0] <= wr_im;
    end
  end

  always_comb begin
    head_re = dl_re[D-1];
    head_im = dl_im[D-1];
    sum_re  = SW'(head_re) + SW'(di_re);
    sum_im  = SW'(head_im) + SW'(di_im);
    dif_re  = SW'(head_re) - SW'(di_re);
    dif_im  = SW'(head_im) - SW'(di_im);
    x_re    = pass_fit(head_re);
    x_im    = pass_fit(head_im);
    wr_re   = di_re;
    wr_im   = di_im;
    if (second_c) begin
      x_re  = bf_fit(sum_re);
      x_im  = bf_fit(sum_im);
      wr_re = bf_fit(dif_re);
      wr_im = bf_fit(dif_im);
    end
  end

  if (CW > 1) begin : g_addr
    assign tw_addr = AW'(eff_cnt[CW-2:0]) << (STAGE - 1);
  end else begin : g_addr0
    assign tw_addr = '0;
  end

  sdf_twiddle_rom #(
    .LOG2_N  (LOG2_N),
    .TW_W    (TW_W),
    .INVERSE (INVERSE)
  ) u_tw_rom (
    .addr  (tw_addr),
    .tw_re (tw_re),
    .tw_im (tw_im)
  );

  logic                     v1, byp1;
  logic signed [DATA_W-1:0] x1_re, x1_im;
  logic signed [TW_W-1:0]   tw1_re, tw1_im;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1     <= 1'b0;
      byp1   <= 1'b0;
      x1_re  <= '0;
      x1_im  <= '0;
      tw1_re <= '0;
      tw1_im <= '0;
    end else begin
      v1 <= valid_c;
      if (valid_c) begin
        byp1   <= second_c;
        x1_re  <= x_re;
        x1_im  <= x_im;
        tw1_re <= tw_re;
        tw1_im <= tw_im;
      end
    end
  end

  logic signed [MW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]     acc_re, acc_im;
  logic signed [DATA_W-1:0] y_re, y_im;

  // Sum-path samples bypass the multiplier: twiddle of exactly 1.
  always_comb begin
    p_rr   = MW'(x1_re) * MW'(tw1_re);
    p_ii   = MW'(x1_im) * MW'(tw1_im);
    p_ri   = MW'(x1_re) * MW'(tw1_im);
    p_ir   = MW'(x1_im) * MW'(tw1_re);
    acc_re = PW'(p_rr) - PW'(p_ii);
    acc_im = PW'(p_ri) + PW'(p_ir);
    y_re   = DATA_W'(sat_to_w(round_shift(64'(acc_re), TW_W - 1), DATA_W));
    y_im   = DATA_W'(sat_to_w(round_shift(64'(acc_im), TW_W - 1), DATA_W));
    if (byp1) begin
      y_re = x1_re;
      y_im = x1_im;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      do_en <= 1'b0;
      do_re <= '0;
      do_im <= '0;
    end else begin
      do_en <= v1;
      if (v1) begin
        do_re <= y_re;
        do_im <= y_im;
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Scoreboard bench for sdf_r2_stage (N=16, STAGE=1, forward); follows SDF_STAGE_SCALE_EN if defined.
module tb_sdf_r2_stage;

  localparam int D   = 8;
  localparam int N   = 16;
  localparam bit INV = 1'b0;
`ifdef SDF_STAGE_SCALE_EN
  localparam bit SCALE  = 1'b1;
  localparam int IMP_A  = 500;
  localparam int IMP_B  = 250;
  localparam int TW_RE  = 177;
  localparam int TW_IM  = -177;
`else
  localparam bit SCALE  = 1'b0;
  localparam int IMP_A  = 1000;
  localparam int IMP_B  = 1000;
  localparam int TW_RE  = 707;
  localparam int TW_IM  = -707;
`endif

  logic               clk = 1'b0;
  logic               rstn;
  logic               di_en, di_sof;
  logic signed [15:0] di_re, di_im;
  logic               do_en;
  logic signed [15:0] do_re, do_im;

  sdf_r2_stage #(
    .DATA_W  (16),
    .TW_W    (16),
    .LOG2_N  (4),
    .STAGE   (1),
    .INVERSE (INV)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .di_en  (di_en),
    .di_sof (di_sof),
    .di_re  (di_re),
    .di_im  (di_im),
    .do_en  (do_en),
    .do_re  (do_re),
    .do_im  (do_im)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int c;
    int re;
    int im;
  } exp_t;

  exp_t sbq[$];
  int   dq_re[$];
  int   dq_im[$];
  int   m_cnt    = 0;
  bit   m_primed = 1'b0;
  int   dut_re[int];
  int   dut_im[int];

  function automatic longint rnd_div(input longint v, input int s);
    longint den, num, q;
    den = longint'(1) << s;
    num = v + den / 2;
    q   = num / den;
    if (num < 0 && q * den != num) q = q - 1;
    return q;
  endfunction

  function automatic int clip16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic int tw_q(input real v);
    real r;
    r = $floor(v * 32768.0 + 0.5);
    if (r > 32767.0) r = 32767.0;
    return $rtoi(r);
  endfunction

  task automatic model_step(input bit sof, input int re, input int im, input int tc);
    longint pr, pi, sr, si, dr, di;
    int     hr, hi, o_re, o_im, n_re, n_im, wr, wi;
    real    ang;
    if (sof) begin
      m_cnt    = 0;
      m_primed = 1'b0;
    end
    hr = dq_re[D-1];
    hi = dq_im[D-1];
    if (m_cnt < D) begin
      pr  = SCALE ? rnd_div(hr, 1) : hr;
      pi  = SCALE ? rnd_div(hi, 1) : hi;
      ang = 2.0 * 3.141592653589793 * real'(m_cnt) / real'(N);
      wr  = tw_q($cos(ang));
      wi  = tw_q($sin(ang));
      if (!INV) wi = -wi;
      o_re = clip16(rnd_div(pr * wr - pi * wi, 15));
      o_im = clip16(rnd_div(pr * wi + pi * wr, 15));
      n_re = re;
      n_im = im;
    end else begin
      m_primed = 1'b1;
      sr = longint'(hr) + re;
      si = longint'(hi) + im;
      dr = longint'(hr) - re;
      di = longint'(hi) - im;
      if (SCALE) begin
        sr = rnd_div(sr, 1);
        si = rnd_div(si, 1);
        dr = rnd_div(dr, 1);
        di = rnd_div(di, 1);
      end
      o_re = clip16(sr);
      o_im = clip16(si);
      n_re = clip16(dr);
      n_im = clip16(di);
    end
    dq_re.delete(D-1);
    dq_im.delete(D-1);
    dq_re.push_front(n_re);
    dq_im.push_front(n_im);
    if (m_primed) sbq.push_back('{tc, o_re, o_im});
    m_cnt = (m_cnt + 1) % (2 * D);
  endtask

  task automatic drive(input bit en, input bit sof, input int re, input int im);
    @(posedge clk);
    #1;
    di_en  = en;
    di_sof = sof;
    di_re  = 16'(re);
    di_im  = 16'(im);
    if (en) model_step(sof, re, im, cyc + 2);
  endtask

  int fr_re[64];
  int fr_im[64];
  int start_cyc;

  task automatic clear_fr();
    for (int i = 0; i < 64; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
  endtask

  task automatic rand_fr(input int n);
    clear_fr();
    for (int i = 0; i < n; i++) begin
      fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
      fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // Bubble pattern repeats en = 1,0,0,1; idle slots carry a stray sof that must be ignored.
  task automatic send(input int n, input bit sof_first, input bit bub);
    int ph;
    int i;
    ph = 0;
    i  = 0;
    while (i < n) begin
      if (bub && (ph % 4 == 1 || ph % 4 == 2)) begin
        drive(1'b0, 1'b1, 12345, -4321);
      end else begin
        drive(1'b1, sof_first && i == 0, fr_re[i], fr_im[i]);
        if (i == 0) start_cyc = cyc - 2 + 2;
        i++;
      end
      ph++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0);
  endtask

  function automatic int get_re(input int c);
    if (dut_re.exists(c)) return dut_re[c];
    return 999999;
  endfunction

  function automatic int get_im(input int c);
    if (dut_im.exists(c)) return dut_im[c];
    return 999999;
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (do_en) begin
        dut_re[cyc] = int'(do_re);
        dut_im[cyc] = int'(do_im);
        if (sbq.size() == 0) begin
          chk("spurious_en", do_en, 0);
        end else begin
          chk("out_cycle", cyc, sbq[0].c);
          chk("out_re", do_re, sbq[0].re);
          chk("out_im", do_im, sbq[0].im);
          sbq.delete(0);
        end
      end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
        chk("missing_en", do_en, 1);
        sbq.delete(0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < D; i++) begin
      dq_re.push_back(0);
      dq_im.push_back(0);
    end
    rstn   = 1'b0;
    di_en  = 1'b0;
    di_sof = 1'b0;
    di_re  = '0;
    di_im  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_do_en", do_en, 0);
    chk("rst_do_re", do_re, 0);
    chk("rst_do_im", do_im, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // impulse
    clear_fr();
    fr_re[0] = 1000;
    send(24, 1'b1, 1'b0);
    idle(4);
    chk("imp_sum_re", get_re(start_cyc + 10), IMP_A);
    chk("imp_sum_im", get_im(start_cyc + 10), 0);
    chk("imp_dif_re", get_re(start_cyc + 18), IMP_B);
    chk("imp_dif_im", get_im(start_cyc + 18), 0);

    // twiddle at k=2
    clear_fr();
    fr_re[2] = 1000;
    send(24, 1'b1, 1'b0);
    idle(4);
    chk("tw2_re", get_re(start_cyc + 20), TW_RE);
    chk("tw2_im", get_im(start_cyc + 20), TW_IM);

    // saturation at both rails
    clear_fr();
    fr_re[0] = 32767;  fr_re[8] = 32767;
    fr_re[1] = -32768; fr_re[9] = -32768;
    fr_im[3] = 32767;  fr_im[11] = 32767;
    send(24, 1'b1, 1'b0);
    idle(4);
    chk("sat_pos_re", get_re(start_cyc + 10), 32767);
    chk("sat_neg_re", get_re(start_cyc + 11), -32768);
    chk("sat_pos_im", get_im(start_cyc + 13), 32767);
    chk("sat_dif_re", get_re(start_cyc + 18), 0);

    // bubbles
    rand_fr(16);
    send(24, 1'b1, 1'b1);
    idle(3);

    // sof mid-block at cnt=5
    rand_fr(5);
    send(5, 1'b1, 1'b0);
    rand_fr(16);
    send(24, 1'b1, 1'b0);
    idle(3);

    // reset mid-frame
    rand_fr(12);
    send(12, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rstn   = 1'b0;
    di_en  = 1'b0;
    di_sof = 1'b0;
    m_cnt    = 0;
    m_primed = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_do_en", do_en, 0);
    chk("midrst_do_re", do_re, 0);
    chk("midrst_do_im", do_im, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold_en", do_en, 0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // cold start after release, no sof
    rand_fr(16);
    send(24, 1'b0, 1'b0);

    // back-to-back frames with flush
    rand_fr(16);
    send(16, 1'b1, 1'b0);
    rand_fr(16);
    send(16, 1'b1, 1'b0);
    clear_fr();
    send(8, 1'b0, 1'b0);
    idle(6);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
